clk_div_multi: RTL and testbench

- Multi-channel programmable clock/tick divider for the Xilinx FPGA top.
- Generalises the fixed 50-to-1 RTC divider to NumChannels independent channels, each with a runtime-loadable half-period divisor and an enable.
- Divisor updates are glitch-free: a shadow register is applied only at a half-period boundary.
- Per channel it produces a 50%-duty divided clock plus a one-cycle tick on each rising edge. It feeds the SoC RTC input and auxiliary timers such as fan PWM timebases.

---
 rtl/clk_div_pkg.sv | 10 +
 rtl/clk_div_multi_if.sv | 33 +++
 rtl/clk_div_chan.sv | 87 ++++++++
 rtl/clk_div_multi.sv | 32 +++
 tb/tb_clk_div_multi.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants for the multi-channel clock divider.
// Instances size their own counters; these are defaults only.
package clk_div_pkg;

  localparam int DefaultCntWidth = 16;
  localparam int DefaultRtcDiv   = 24;

  typedef logic [DefaultCntWidth-1:0] cnt_t;

endpackage

// File: rtl/clk_div_multi_if.sv
// Control/status bundle of the multi-channel divider.
// master drives enables and divisors, slave returns clocks.
interface clk_div_multi_if #(
  parameter int NumChannels = 2,
  parameter int CntWidth    = 16
);

  logic [NumChannels-1:0]          en_i;
  logic [NumChannels*CntWidth-1:0] div_i;
  logic [NumChannels-1:0]          div_load_i;
  logic [NumChannels-1:0]          clk_o;
  logic [NumChannels-1:0]          tick_o;
  logic [NumChannels-1:0]          pending_o;

  modport master (
    output en_i,
    output div_i,
    output div_load_i,
    input  clk_o,
    input  tick_o,
    input  pending_o
  );

  modport slave (
    input  en_i,
    input  div_i,
    input  div_load_i,
    output clk_o,
    output tick_o,
    output pending_o
  );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow divisor,
// registered 50%-duty clock, rise tick and pending flag.
module clk_div_chan #(
  parameter int CntWidth   = 16,
  parameter int DefaultDiv = 24
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [CntWidth-1:0] div_i,
  input  logic                load_i,
  output logic                clk_o,
  output logic                tick_o,
  output logic                pending_o
);

  typedef logic [CntWidth-1:0] cnt_t;

  localparam cnt_t ResetDiv = cnt_t'(DefaultDiv);

  cnt_t cnt_q;
  cnt_t cnt_d;
  cnt_t act_q;
  cnt_t act_d;
  cnt_t shd_q;
  cnt_t shd_d;
  logic clk_d;
  logic tick_d;
  logic pend_d;
  logic bnd;

  assign bnd = (cnt_q == act_q);

  // Next state: disable wins over a boundary; a new
  // divisor only takes effect at a half-period edge.
  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    shd_d  = shd_q;
    clk_d  = clk_o;
    tick_d = 1'b0;
    pend_d = pending_o;
    if (!en_i) begin
      cnt_d  = '0;
      clk_d  = 1'b0;
      pend_d = 1'b0;
      shd_d  = load_i ? div_i : shd_q;
      act_d  = load_i ? div_i : shd_q;
    end else begin
      if (load_i) begin
        shd_d = div_i;
      end
      if (bnd) begin
        cnt_d  = '0;
        clk_d  = ~clk_o;
        tick_d = ~clk_o;
        act_d  = load_i ? div_i : shd_q;
        pend_d = 1'b0;
      end else begin
        cnt_d = cnt_q + cnt_t'(1);
        if (load_i) begin
          pend_d = 1'b1;
        end
      end
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      act_q     <= ResetDiv;
      shd_q     <= ResetDiv;
      clk_o     <= 1'b0;
      tick_o    <= 1'b0;
      pending_o <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      act_q     <= act_d;
      shd_q     <= shd_d;
      clk_o     <= clk_d;
      tick_o    <= tick_d;
      pending_o <= pend_d;
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock/tick divider.
// Each channel runs independently on its own divisor slice.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NumChannels = 2,
  parameter int CntWidth    = DefaultCntWidth,
  parameter int DefaultDiv  = DefaultRtcDiv
) (
  input  logic            clk_i,
  input  logic            rst_i,
  clk_div_multi_if.slave  bus
);

  // One divider instance per channel.
  for (genvar c = 0; c < NumChannels; c++) begin : g_chan
    clk_div_chan #(
      .CntWidth   (CntWidth),
      .DefaultDiv (DefaultDiv)
    ) u_chan (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .en_i      (bus.en_i[c]),
      .div_i     (bus.div_i[c*CntWidth +: CntWidth]),
      .load_i    (bus.div_load_i[c]),
      .clk_o     (bus.clk_o[c]),
      .tick_o    (bus.tick_o[c]),
      .pending_o (bus.pending_o[c])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi.
// Tick times go to per-channel queues; a monitor pops them.
module tb_clk_div_multi;
  import clk_div_pkg::*;

  localparam int NCH = 2;
  localparam int CW  = DefaultCntWidth;

  localparam int T0A[11] = '{25, 75, 108, 124, 140, 156,
                             173, 179, 185, 191, 197};
  localparam int T1A[9]  = '{25, 75, 104, 112, 120, 128,
                             142, 162, 182};
  localparam int T0B[9]  = '{203, 205, 207, 209, 211,
                             213, 215, 217, 219};
  localparam int T1B[1]  = '{213};
  localparam int TC[2]   = '{247, 297};

  logic clk = 1'b0;
  logic rst;

  clk_div_multi_if #(
    .NumChannels (NCH),
    .CntWidth    (CW)
  ) bus ();

  clk_div_multi #(
    .NumChannels (NCH),
    .CntWidth    (CW),
    .DefaultDiv  (DefaultRtcDiv)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  int base     = 0;
  int exp_q [NCH][$];

  task automatic check(input string nm, input int got,
                       input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d cyc=%0d",
               nm, got, exp, cyc - base);
    end
  endtask

  task automatic push(input int c, input int off);
    exp_q[c].push_back(base + off);
  endtask

  task automatic wait_to(input int off);
    while (cyc < base + off) @(negedge clk);
  endtask

  task automatic set_div(input int c, input int v);
    bus.div_i[c*CW +: CW] = CW'(v);
  endtask

  // Monitor: every tick must match the next queued time.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int c = 0; c < NCH; c++) begin
          if (exp_q[c].size() != 0 && exp_q[c][0] < cyc) begin
            e = exp_q[c].pop_front();
            check($sformatf("tick%0d_missing", c),
                  cyc - base, e - base);
          end
          if (bus.tick_o[c]) begin
            if (exp_q[c].size() == 0) begin
              check($sformatf("tick%0d_unexpected", c),
                    cyc - base, -1);
            end else begin
              e = exp_q[c].pop_front();
              check($sformatf("tick%0d_time", c),
                    cyc - base, e - base);
            end
          end
        end
      end
    end
  end

  // Stimulus with directed probes.
  initial begin
    rst            = 1'b1;
    bus.en_i       = '0;
    bus.div_i      = '0;
    bus.div_load_i = '0;
    repeat (3) @(negedge clk);
    check("rst_clk", int'(bus.clk_o), 0);
    check("rst_tick", int'(bus.tick_o), 0);
    check("rst_pend", int'(bus.pending_o), 0);

    base = cyc;
    foreach (T0A[i]) push(0, T0A[i]);
    foreach (T1A[i]) push(1, T1A[i]);
    rst      = 1'b0;
    bus.en_i = 2'b11;

    wait_to(24);  check("c0_pre", int'(bus.clk_o[0]), 0);
    wait_to(25);  check("c0_rise", int'(bus.clk_o[0]), 1);
    wait_to(30);  check("c0_pend", int'(bus.pending_o[0]), 0);
    wait_to(49);  check("c0_hi", int'(bus.clk_o[0]), 1);
    wait_to(50);  check("c0_fall", int'(bus.clk_o[0]), 0);

    wait_to(85);
    set_div(1, 3);
    bus.div_load_i = 2'b10;
    @(negedge clk);
    bus.div_load_i = 2'b00;
    check("c1_pend_set", int'(bus.pending_o[1]), 1);

    wait_to(99);
    check("c1_pend_hold", int'(bus.pending_o[1]), 1);
    set_div(0, 7);
    bus.div_load_i = 2'b01;
    @(negedge clk);
    bus.div_load_i = 2'b00;
    check("c1_pend_clr", int'(bus.pending_o[1]), 0);
    check("c0_pend_bnd", int'(bus.pending_o[0]), 0);
    check("c1_fall100", int'(bus.clk_o[1]), 0);
    @(negedge clk);
    check("c0_pend_bnd2", int'(bus.pending_o[0]), 0);

    wait_to(103); check("c1_lo103", int'(bus.clk_o[1]), 0);
    wait_to(104); check("c1_hi104", int'(bus.clk_o[1]), 1);
    wait_to(107); check("c1_hi107", int'(bus.clk_o[1]), 1);
    check("c0_lo107", int'(bus.clk_o[0]), 0);
    wait_to(108); check("c1_lo108", int'(bus.clk_o[1]), 0);
    check("c0_hi108", int'(bus.clk_o[0]), 1);
    wait_to(115); check("c0_hi115", int'(bus.clk_o[0]), 1);
    wait_to(116); check("c0_lo116", int'(bus.clk_o[0]), 0);

    wait_to(129);
    set_div(1, 5);
    bus.div_load_i = 2'b10;
    @(negedge clk);
    set_div(1, 9);
    check("c1_pend_a", int'(bus.pending_o[1]), 1);
    @(negedge clk);
    bus.div_load_i = 2'b00;
    check("c1_pend_b", int'(bus.pending_o[1]), 1);
    @(negedge clk);
    check("c1_pend_c", int'(bus.pending_o[1]), 0);
    check("c1_lo132", int'(bus.clk_o[1]), 0);
    wait_to(141); check("c1_lo141", int'(bus.clk_o[1]), 0);
    wait_to(142); check("c1_hi142", int'(bus.clk_o[1]), 1);
    wait_to(151); check("c1_hi151", int'(bus.clk_o[1]), 1);
    wait_to(152); check("c1_lo152", int'(bus.clk_o[1]), 0);

    wait_to(159);
    set_div(0, 2);
    bus.div_load_i = 2'b01;
    @(negedge clk);
    bus.div_load_i = 2'b00;
    check("c0_pend_d", int'(bus.pending_o[0]), 1);
    check("c0_hi160", int'(bus.clk_o[0]), 1);
    @(negedge clk);
    bus.en_i = 2'b10;
    check("c0_pend_e", int'(bus.pending_o[0]), 1);
    @(negedge clk);
    check("c0_dis_clk", int'(bus.clk_o[0]), 0);
    check("c0_dis_tick", int'(bus.tick_o[0]), 0);
    check("c0_dis_pend", int'(bus.pending_o[0]), 0);
    wait_to(170);
    bus.en_i = 2'b11;
    wait_to(172); check("c0_lo172", int'(bus.clk_o[0]), 0);
    wait_to(173); check("c0_hi173", int'(bus.clk_o[0]), 1);
    wait_to(174); check("c0_tick_w", int'(bus.tick_o[0]), 0);
    wait_to(176); check("c0_lo176", int'(bus.clk_o[0]), 0);

    wait_to(200);
    foreach (T0B[i]) push(0, T0B[i]);
    foreach (T1B[i]) push(1, T1B[i]);
    bus.en_i = 2'b00;
    set_div(0, 0);
    set_div(1, 10);
    bus.div_load_i = 2'b11;
    @(negedge clk);
    bus.div_load_i = 2'b00;
    check("dis_load_pend", int'(bus.pending_o), 0);
    @(negedge clk);
    bus.en_i = 2'b11;
    wait_to(203); check("c0_hi203", int'(bus.clk_o[0]), 1);
    wait_to(204); check("c0_lo204", int'(bus.clk_o[0]), 0);
    wait_to(212); check("c1_lo212", int'(bus.clk_o[1]), 0);
    wait_to(213); check("c1_hi213", int'(bus.clk_o[1]), 1);

    wait_to(220);
    foreach (TC[i]) begin
      push(0, TC[i]);
      push(1, TC[i]);
    end
    rst = 1'b1;
    #1;
    check("arst_clk", int'(bus.clk_o), 0);
    check("arst_tick", int'(bus.tick_o), 0);
    check("arst_pend", int'(bus.pending_o), 0);
    wait_to(222);
    rst = 1'b0;
    wait_to(246); check("post_lo246", int'(bus.clk_o), 0);
    wait_to(247); check("post_hi247", int'(bus.clk_o), 3);
    check("post_pend", int'(bus.pending_o), 0);
    wait_to(271); check("post_hi271", int'(bus.clk_o), 3);
    wait_to(272); check("post_lo272", int'(bus.clk_o), 0);

    wait_to(300);
    @(negedge clk);
    check("q0_drained", exp_q[0].size(), 0);
    check("q1_drained", exp_q[1].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
